cim_ark_sbox_bank: RTL and testbench
====================================

Name: cim_ark_sbox_bank

Overview:
- Synthesizable model of the CIM read-out array that sits directly downstream of the AES controller.
- Consumes the controller's 16-bit IN stream, two state bytes per beat over 8 beats. For each beat it applies AddRoundKey using an internal round-key store and mirrors the result onto the RIO bytes.
- After the 8th beat it performs the S-box lookup on all 16 bytes and drives the results back on RIO_00..RIO_15.
- Replaces the behavioural array model so full-chip simulation and FPGA prototyping can run without an external RAM file.

Parameters:
- NROUNDS, 10, highest round-key index; the key store holds NROUNDS+1 entries.
- KEY_W, 128, round-key width in bits.

Ports:
- CLK  in  1  clock.
- RSTn  in  1  synchronous active-low reset, sampled on rising CLK.
- START  in  1  one-cycle pulse: begin a new block; clears the round counter and beat counter.
- IN_VLD  in  1  IN carries a valid byte pair this cycle.
- IN  in  16  byte pair: IN[15:8] = byte 2p, IN[7:0] = byte 2p+1.
- KWR  in  1  round-key write strobe.
- KADDR  in  4  round-key index 0..NROUNDS.
- KDATA  in  KEY_W  round key; byte 0 is at [127:120].
- RIO_00..RIO_15  out  8 each  read-out bytes to the controller.
- RVLD  out  1  one-cycle pulse: RIO holds S-box results.
- ROUND  out  4  current round index.
- BUSY  out  1  high in COLLECT or LOOKUP.
- ERR  out  1  sticky: IN_VLD received while in LOOKUP.

Behaviour:
- Reset (RSTn=0 at posedge):
  - RIO_xx=0, RVLD=0, ROUND=0, BUSY=0, ERR=0.
  - Beat counter p=0, address registers = 0, state IDLE.
  - Key store is not reset.
- FSM states and transitions:
  - IDLE → COLLECT on START.
  - COLLECT → LOOKUP on the IN_VLD beat with p==7.
  - LOOKUP → COLLECT after 1 cycle (2 cycles if the optional feature is on).
  - START in any state → COLLECT with p=0 and ROUND=0. The partial block is discarded, RIO is unchanged, and no RVLD is issued.
- COLLECT, each IN_VLD beat:
  - a = IN[15:8] ^ K[ROUND][byte 2p]; b = IN[7:0] ^ K[ROUND][byte 2p+1].
  - RIO_(2p) and ADDR(2p) ← a; RIO_(2p+1) and ADDR(2p+1) ← b.
  - p increments; after p==7 it wraps to 0.
  - Beats with IN_VLD=0 stall the counter; the beats need not be contiguous.
- LOOKUP:
  - All 16 RIO_j ← SBOX(ADDR(j)) in the same cycle.
  - RVLD pulses high the cycle the new values appear on RIO.
  - ROUND increments, saturating at NROUNDS (further blocks reuse K[NROUNDS]).
  - IN_VLD during LOOKUP is dropped and sets ERR. ERR clears only on reset.
- Latency: from the 8th accepted beat to RVLD is 1 cycle (2 cycles with the optional feature).
- Key store:
  - KWR writes K[KADDR] ← KDATA at posedge.
  - KADDR > NROUNDS: the write is ignored.
  - A write to K[ROUND] coinciding with a COLLECT beat: that beat uses the old key value (read-before-write).
- SBOX: combinational, standard FIPS-197 forward table; no inverse table.
- Simultaneous START and IN_VLD: START wins. The beat is taken as beat 0 of the new block, using K[0].

Optional Feature:
- Macro CIM_LOOKUP_PIPE_EN.
- Defined: the S-box output is registered, modelling a synchronous array read.
  - LOOKUP lasts 2 cycles; RVLD fires in the second cycle.
  - IN_VLD during either cycle sets ERR.
- Undefined: single-cycle LOOKUP as described above.

Decomposition:
- Package cim_aes_pkg holds:
  - FSM state enum (IDLE, COLLECT, LOOKUP).
  - NROUNDS default.
  - Byte-select helper function.
  - 256-entry SBOX constant function.
- One sub-module: cim_sbox8 (8-bit in, 8-bit out, pure combinational). Instantiate it 16 times.

Test Plan:
- FIPS-197 key 000102..0e0f loaded into K[0]..K[10] (K[1]=d6aa74fdd2af72fadaa678f1d6ab76fe, ...).
  - START, then 8 beats of 0011,2233,...,eeff → RIO before lookup = 00102030405060708090a0b0c0d0e0f0.
  - RVLD 1 cycle after beat 8 with RIO = 63cab7040953d051cd60e0e7ba70e18c; ROUND=1.
- Beats interleaved with IN_VLD=0 gaps of 1–3 cycles → identical RIO/RVLD result; RVLD exactly 1 cycle after the last beat.
- START asserted after 4 beats → no RVLD; p and ROUND reset; the next 8 beats produce the correct round-0 result.
- 12 consecutive blocks → ROUND saturates at 10; blocks 11 and 12 use K[10].
- IN_VLD asserted in the LOOKUP cycle → ERR=1, beat dropped, p unchanged. ERR stays high until RSTn=0, then clears along with all outputs.
- With CIM_LOOKUP_PIPE_EN defined, first scenario → RVLD 2 cycles after beat 8 with the same RIO values.

Source files
------------

// File: rtl/cim_aes_pkg.sv
// Shared types and helpers for the CIM read-out array: FSM states, default sizes,
// byte selection and the forward AES S-box table.
package cim_aes_pkg;

  localparam int NROUNDS_DEF = 10;
  localparam int KEY_W_DEF   = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    LOOKUP  = 2'd2
  } cim_state_e;

  // Row-major FIPS-197 forward S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_f(input logic [7:0] x);
    logic [2047:0] s;
    s = SBOX_TBL << {x, 3'b000};
    return s[2047:2040];
  endfunction

  // Byte idx of a 128-bit word, byte 0 in bits [127:120].
  function automatic logic [7:0] key_byte(input logic [127:0] k, input logic [3:0] idx);
    logic [127:0] s;
    s = k << {idx, 3'b000};
    return s[127:120];
  endfunction

endpackage

// File: rtl/cim_sbox8.sv
// Single-byte forward AES S-box, purely combinational.
module cim_sbox8
  import cim_aes_pkg::*;
(
  input  logic [7:0] din_i,
  output logic [7:0] dout_o
);

  assign dout_o = sbox_f(din_i);

endmodule

// File: rtl/cim_ark_sbox_bank.sv
// CIM read-out array: per-beat AddRoundKey into 16 address bytes, then a 16-wide S-box lookup.
// Define CIM_LOOKUP_PIPE_EN to register the S-box output (two-cycle LOOKUP).
module cim_ark_sbox_bank
  import cim_aes_pkg::*;
#(
  parameter int NROUNDS = NROUNDS_DEF,
  parameter int KEY_W   = KEY_W_DEF
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             START,
  input  logic             IN_VLD,
  input  logic [15:0]      IN,
  input  logic             KWR,
  input  logic [3:0]       KADDR,
  input  logic [KEY_W-1:0] KDATA,
  output logic [7:0]       RIO_00,
  output logic [7:0]       RIO_01,
  output logic [7:0]       RIO_02,
  output logic [7:0]       RIO_03,
  output logic [7:0]       RIO_04,
  output logic [7:0]       RIO_05,
  output logic [7:0]       RIO_06,
  output logic [7:0]       RIO_07,
  output logic [7:0]       RIO_08,
  output logic [7:0]       RIO_09,
  output logic [7:0]       RIO_10,
  output logic [7:0]       RIO_11,
  output logic [7:0]       RIO_12,
  output logic [7:0]       RIO_13,
  output logic [7:0]       RIO_14,
  output logic [7:0]       RIO_15,
  output logic             RVLD,
  output logic [3:0]       ROUND,
  output logic             BUSY,
  output logic             ERR
);

  localparam logic [3:0] NR4 = 4'(NROUNDS);

  cim_state_e        state_q, state_d;
  logic [2:0]        p_q, p_d;
  logic [3:0]        round_q, round_d;
  logic [15:0][7:0]  addr_q, addr_d;
  logic [15:0][7:0]  rio_q, rio_d;
  logic              rvld_q, rvld_d;
  logic              err_q, err_d;
  logic [15:0][7:0]  sbox_out;
  logic [15:0][7:0]  lookup_res;

  logic [KEY_W-1:0]  kmem_q [0:NROUNDS];
  logic [KEY_W-1:0]  kcur;
  logic              beat;
  logic [2:0]        bsel;
  logic [3:0]        ksel;
  logic [7:0]        byte_a, byte_b;

  // Key store has no reset; reads see the pre-edge contents, so a beat racing a write uses the old key.
  always_ff @(posedge CLK) begin
    if (KWR && (KADDR <= NR4))
      kmem_q[KADDR] <= KDATA;
  end

  for (genvar j = 0; j < 16; j++) begin : g_sbox
    cim_sbox8 u_sbox (
      .din_i  (addr_q[j]),
      .dout_o (sbox_out[j])
    );
  end

`ifdef CIM_LOOKUP_PIPE_EN
  logic             lk_q, lk_d;
  logic [15:0][7:0] sbox_q;

  always_ff @(posedge CLK) begin
    if (!RSTn)
      sbox_q <= '0;
    else if (state_q == LOOKUP && !lk_q)
      sbox_q <= sbox_out;
  end

  assign lookup_res = sbox_q;
`else
  assign lookup_res = sbox_out;
`endif

  // START takes precedence: a coincident beat becomes beat 0 of the new block under K[0].
  always_comb begin
    beat = 1'b0;
    bsel = p_q;
    ksel = round_q;
    if (START) begin
      beat = IN_VLD;
      bsel = '0;
      ksel = '0;
    end else if (state_q == COLLECT) begin
      beat = IN_VLD;
    end
  end

  assign kcur   = kmem_q[ksel];
  assign byte_a = IN[15:8] ^ key_byte(kcur, {bsel, 1'b0});
  assign byte_b = IN[7:0]  ^ key_byte(kcur, {bsel, 1'b1});

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    round_d = round_q;
    addr_d  = addr_q;
    rio_d   = rio_q;
    rvld_d  = 1'b0;
    err_d   = err_q;
`ifdef CIM_LOOKUP_PIPE_EN
    lk_d    = 1'b0;
`endif
    if (START) begin
      state_d = COLLECT;
      round_d = '0;
      p_d     = IN_VLD ? 3'd1 : 3'd0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (IN_VLD) begin
            p_d = p_q + 3'd1;
            if (p_q == 3'd7)
              state_d = LOOKUP;
          end
        end
        LOOKUP: begin
          if (IN_VLD)
            err_d = 1'b1;
`ifdef CIM_LOOKUP_PIPE_EN
          if (!lk_q) begin
            lk_d = 1'b1;
          end else begin
`endif
            rio_d   = lookup_res;
            rvld_d  = 1'b1;
            state_d = COLLECT;
            round_d = (round_q == NR4) ? round_q : round_q + 4'd1;
`ifdef CIM_LOOKUP_PIPE_EN
          end
`endif
        end
        default: ;
      endcase
    end
    if (beat) begin
      addr_d[{bsel, 1'b0}] = byte_a;
      addr_d[{bsel, 1'b1}] = byte_b;
      rio_d[{bsel, 1'b0}]  = byte_a;
      rio_d[{bsel, 1'b1}]  = byte_b;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q <= IDLE;
      p_q     <= '0;
      round_q <= '0;
      addr_q  <= '0;
      rio_q   <= '0;
      rvld_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef CIM_LOOKUP_PIPE_EN
      lk_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      round_q <= round_d;
      addr_q  <= addr_d;
      rio_q   <= rio_d;
      rvld_q  <= rvld_d;
      err_q   <= err_d;
`ifdef CIM_LOOKUP_PIPE_EN
      lk_q    <= lk_d;
`endif
    end
  end

  assign RIO_00 = rio_q[0];
  assign RIO_01 = rio_q[1];
  assign RIO_02 = rio_q[2];
  assign RIO_03 = rio_q[3];
  assign RIO_04 = rio_q[4];
  assign RIO_05 = rio_q[5];
  assign RIO_06 = rio_q[6];
  assign RIO_07 = rio_q[7];
  assign RIO_08 = rio_q[8];
  assign RIO_09 = rio_q[9];
  assign RIO_10 = rio_q[10];
  assign RIO_11 = rio_q[11];
  assign RIO_12 = rio_q[12];
  assign RIO_13 = rio_q[13];
  assign RIO_14 = rio_q[14];
  assign RIO_15 = rio_q[15];
  assign RVLD   = rvld_q;
  assign ROUND  = round_q;
  assign BUSY   = (state_q != IDLE);
  assign ERR    = err_q;

endmodule

// File: tb/tb_cim_ark_sbox_bank.sv
// Directed bench for cim_ark_sbox_bank using the FIPS-197 AES-128 key schedule.
module tb_cim_ark_sbox_bank;

`ifdef CIM_LOOKUP_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam logic [127:0] TGT0  = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] POST0 = 128'h63cab7040953d051cd60e0e7ba70e18c;
  localparam logic [127:0] POSTZ = {16{8'h63}};
  localparam logic [127:0] PT0   = 128'h00112233445566778899aabbccddeeff;

  logic         CLK = 1'b0;
  logic         RSTn, START, IN_VLD, KWR;
  logic [15:0]  IN;
  logic [3:0]   KADDR;
  logic [127:0] KDATA;
  logic [7:0]   RIO_00, RIO_01, RIO_02, RIO_03, RIO_04, RIO_05, RIO_06, RIO_07;
  logic [7:0]   RIO_08, RIO_09, RIO_10, RIO_11, RIO_12, RIO_13, RIO_14, RIO_15;
  logic         RVLD, BUSY, ERR;
  logic [3:0]   ROUND;

  int tests = 0;
  int fails = 0;

  logic [127:0] keys [0:10];

  typedef struct {
    logic [127:0] pt;
    logic [127:0] pre;
    logic [127:0] post;
    bit           gaps;
  } vec_t;

  vec_t vecs [4];

  always #5 CLK = ~CLK;

  cim_ark_sbox_bank dut (
    .CLK(CLK), .RSTn(RSTn), .START(START), .IN_VLD(IN_VLD), .IN(IN),
    .KWR(KWR), .KADDR(KADDR), .KDATA(KDATA),
    .RIO_00(RIO_00), .RIO_01(RIO_01), .RIO_02(RIO_02), .RIO_03(RIO_03),
    .RIO_04(RIO_04), .RIO_05(RIO_05), .RIO_06(RIO_06), .RIO_07(RIO_07),
    .RIO_08(RIO_08), .RIO_09(RIO_09), .RIO_10(RIO_10), .RIO_11(RIO_11),
    .RIO_12(RIO_12), .RIO_13(RIO_13), .RIO_14(RIO_14), .RIO_15(RIO_15),
    .RVLD(RVLD), .ROUND(ROUND), .BUSY(BUSY), .ERR(ERR)
  );

  function automatic logic [127:0] rio_all();
    return {RIO_00, RIO_01, RIO_02, RIO_03, RIO_04, RIO_05, RIO_06, RIO_07,
            RIO_08, RIO_09, RIO_10, RIO_11, RIO_12, RIO_13, RIO_14, RIO_15};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic write_key(input logic [3:0] a, input logic [127:0] d);
    KWR = 1'b1; KADDR = a; KDATA = d;
    step();
    KWR = 1'b0;
  endtask

  task automatic start_pulse();
    START = 1'b1;
    step();
    START = 1'b0;
  endtask

  task automatic do_beat(input logic [15:0] d);
    IN = d; IN_VLD = 1'b1;
    step();
    IN_VLD = 1'b0;
  endtask

  // mode 0: plain beats; 1: START rides on beat 0; 2: K[0] <- 0 written on beat 0
  task automatic run_block(input string nm, input logic [127:0] pt, input logic [127:0] pre,
                           input logic [127:0] post, input bit gaps, input int mode,
                           input logic [3:0] exp_round);
    for (int i = 0; i < 8; i++) begin
      if (gaps && i > 0)
        repeat ((i % 3) + 1) step();
      if (i == 0 && mode == 1) START = 1'b1;
      if (i == 0 && mode == 2) begin KWR = 1'b1; KADDR = 4'd0; KDATA = '0; end
      do_beat(pt[127-16*i -: 16]);
      START = 1'b0; KWR = 1'b0;
      if (i == 0 && mode == 1) chk({nm, " round after start beat"}, 128'(ROUND), 128'd0);
    end
    chk({nm, " pre-lookup rio"}, rio_all(), pre);
    chk({nm, " rvld early"}, 128'(RVLD), 128'd0);
    for (int w = 1; w < LAT; w++) begin
      step();
      chk({nm, " rvld pipe early"}, 128'(RVLD), 128'd0);
    end
    step();
    chk({nm, " rvld"}, 128'(RVLD), 128'd1);
    chk({nm, " sbox rio"}, rio_all(), post);
    chk({nm, " round"}, 128'(ROUND), 128'(exp_round));
  endtask

  initial begin
    logic [127:0] snap, pt, tgt, post;
    int r;

    keys[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    keys[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    keys[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    keys[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    keys[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
    keys[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    keys[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    keys[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
    keys[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
    keys[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
    keys[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    vecs[0] = '{PT0, TGT0, POST0, 1'b0};
    vecs[1] = '{PT0, TGT0, POST0, 1'b1};
    vecs[2] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h0, POSTZ, 1'b0};
    vecs[3] = '{128'h0103010701030_10f0103010701030_11f,
                128'h0102030405060708090a0b0c0d0e0f10,
                128'h7c777bf26b6fc53001672bfed7ab76ca, 1'b1};

    RSTn = 1'b0; START = 1'b0; IN_VLD = 1'b0; IN = '0;
    KWR = 1'b0; KADDR = '0; KDATA = '0;
    repeat (3) step();
    chk("reset rio", rio_all(), 128'h0);
    chk("reset rvld", 128'(RVLD), 128'd0);
    chk("reset round", 128'(ROUND), 128'd0);
    chk("reset busy", 128'(BUSY), 128'd0);
    chk("reset err", 128'(ERR), 128'd0);
    RSTn = 1'b1;
    step();

    for (int k = 0; k <= 10; k++) write_key(4'(k), keys[k]);
    write_key(4'd11, {16{8'ha5}});
    write_key(4'd15, {16{8'h5a}});

    for (int v = 0; v < 4; v++) begin
      start_pulse();
      chk($sformatf("vec%0d busy after start", v), 128'(BUSY), 128'd1);
      chk($sformatf("vec%0d round after start", v), 128'(ROUND), 128'd0);
      run_block($sformatf("vec%0d", v), vecs[v].pt, vecs[v].pre, vecs[v].post, vecs[v].gaps, 0, 4'd1);
      step();
      chk($sformatf("vec%0d rvld one-shot", v), 128'(RVLD), 128'd0);
    end

    // abort mid-block: RIO holds, nothing fires, next block restarts at beat 0 / round 0
    run_block("pre-abort", PT0, TGT0, POST0, 1'b0, 1, 4'd1);
    for (int i = 0; i < 4; i++) do_beat(PT0[127-16*i -: 16] ^ 16'hffff);
    snap = rio_all();
    start_pulse();
    chk("abort rio held", rio_all(), snap);
    chk("abort round", 128'(ROUND), 128'd0);
    repeat (3) begin
      chk("abort no rvld", 128'(RVLD), 128'd0);
      step();
    end
    run_block("after abort", PT0, TGT0, POST0, 1'b0, 0, 4'd1);

    // START with IN_VLD while ROUND=1: beat 0 must use K[0]
    run_block("start+beat", PT0, TGT0, POST0, 1'b0, 1, 4'd1);

    // key write racing beat 0 of round 0: beat 0 old key, beats 1..7 zero key
    start_pulse();
    run_block("rd-before-wr", PT0, 128'h00102233445566778899aabbccddeeff,
              128'h63ca93c31bfc33f5c4eeacea4bc12816, 1'b0, 2, 4'd1);
    write_key(4'd0, keys[0]);

    // 12 back-to-back blocks: ROUND saturates, blocks 11/12 reuse K[10]
    start_pulse();
    for (int b = 0; b < 12; b++) begin
      r    = (b > 10) ? 10 : b;
      tgt  = (b % 2 == 0) ? TGT0 : 128'h0;
      post = (b % 2 == 0) ? POST0 : POSTZ;
      pt   = keys[r] ^ tgt;
      run_block($sformatf("sat blk%0d", b + 1), pt, tgt, post, 1'b0, 0, 4'((b + 1 > 10) ? 10 : b + 1));
    end

    // IN_VLD during LOOKUP: dropped, ERR sticky until reset
    chk("err before", 128'(ERR), 128'd0);
    for (int i = 0; i < 8; i++) do_beat(keys[10][127-16*i -: 16] ^ TGT0[127-16*i -: 16]);
    IN = 16'hdead; IN_VLD = 1'b1;
    step();
    IN_VLD = 1'b0;
    chk("err set", 128'(ERR), 128'd1);
    for (int w = 1; w < LAT; w++) step();
    chk("err blk rvld", 128'(RVLD), 128'd1);
    chk("err blk rio", rio_all(), POST0);
    run_block("after err", keys[10], 128'h0, POSTZ, 1'b1, 0, 4'd10);
    chk("err sticky", 128'(ERR), 128'd1);

    RSTn = 1'b0;
    step();
    RSTn = 1'b1;
    chk("final reset err", 128'(ERR), 128'd0);
    chk("final reset rio", rio_all(), 128'h0);
    chk("final reset round", 128'(ROUND), 128'd0);
    chk("final reset busy", 128'(BUSY), 128'd0);
    chk("final reset rvld", 128'(RVLD), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
